led_scanner: RTL and testbench

LED_SCANNER -- requirements
Module: led_scanner

---
 rtl/led_scan_pkg.sv | 16 +
 rtl/led_scanner_tick_gen.sv | 33 +++
 rtl/led_scanner.sv | 111 +++++++++++
 tb/tb_led_scanner.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_scan_pkg.sv
// Shared types for the LED scanner: scan mode encoding and scan direction.
package led_scan_pkg;

    typedef enum logic [1:0] {
        BOUNCE    = 2'd0,
        WRAP_UP   = 2'd1,
        WRAP_DOWN = 2'd2,
        FILL      = 2'd3
    } scan_mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } scan_dir_e;

endpackage

// File: rtl/led_scanner_tick_gen.sv
// Prescaler: counts enabled cycles 0..DIV-1 and flags the last one as a scan tick.
module tick_gen #(
    parameter int unsigned DIV = 1
) (
    input  logic inclk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        tick    = enable && (count_q == CNT_MAX);
        count_d = count_q;
        if (enable) begin
            count_d = tick ? '0 : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge inclk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/led_scanner.sv
// LED scanner: steps a position through BOUNCE / WRAP_UP / WRAP_DOWN / FILL
// patterns at the prescaled rate and decodes it onto the LED drive.
module led_scanner
    import led_scan_pkg::*;
#(
    parameter int unsigned N_LEDS = 8,
    parameter int unsigned DIV    = 1
) (
    input  logic                      inclk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [1:0]                mode,
    output logic [N_LEDS-1:0]         lights,
    output logic [$clog2(N_LEDS)-1:0] position,
    output logic                      cycle_done
);

    localparam int unsigned POS_W = $clog2(N_LEDS);
    localparam int unsigned LED_W = N_LEDS;
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(N_LEDS - 1);

    logic             tick;
    scan_mode_e       mode_e;
    scan_dir_e        step_dir;
    logic [POS_W-1:0] pos_q;
    logic [POS_W-1:0] pos_d;
    scan_dir_e        dir_q;
    scan_dir_e        dir_d;
    logic             cycle_done_q;
    logic             cycle_done_d;

    tick_gen #(
        .DIV(DIV)
    ) u_tick_gen (
        .inclk (inclk),
        .reset (reset),
        .enable(enable),
        .tick  (tick)
    );

    assign mode_e = scan_mode_e'(mode);

    // Mode is sampled at each tick, so a mode change takes effect on the next step.
    always_comb begin
        pos_d        = pos_q;
        dir_d        = dir_q;
        cycle_done_d = 1'b0;
        step_dir     = dir_q;

        case (mode_e)
            BOUNCE: begin
                if (pos_q == POS_MAX) begin
                    step_dir = DIR_DOWN;
                end else if (pos_q == '0) begin
                    step_dir = DIR_UP;
                end else begin
                    step_dir = dir_q;
                end
            end
            WRAP_DOWN: step_dir = DIR_DOWN;
            WRAP_UP:   step_dir = DIR_UP;
            FILL:      step_dir = DIR_UP;
            default:   step_dir = DIR_UP;
        endcase

        if (tick) begin
            if (step_dir == DIR_UP) begin
                pos_d = (pos_q == POS_MAX) ? '0 : pos_q + POS_W'(1);
            end else begin
                pos_d = (pos_q == '0) ? POS_MAX : pos_q - POS_W'(1);
            end

            dir_d = step_dir;
            // Bounce turns around on the step that lands on an endpoint.
            if (mode_e == BOUNCE) begin
                if (pos_d == POS_MAX) begin
                    dir_d = DIR_DOWN;
                end else if (pos_d == '0) begin
                    dir_d = DIR_UP;
                end
            end

            cycle_done_d = (mode_e == WRAP_DOWN) ? (pos_d == POS_MAX) : (pos_d == '0);
        end
    end

    always_ff @(posedge inclk or posedge reset) begin
        if (reset) begin
            pos_q        <= '0;
            dir_q        <= DIR_UP;
            cycle_done_q <= 1'b0;
        end else begin
            pos_q        <= pos_d;
            dir_q        <= dir_d;
            cycle_done_q <= cycle_done_d;
        end
    end

    // Lights decode straight from the registered position; at position 0 every mode shows bit 0.
    always_comb begin
        if (mode_e == FILL) begin
            lights = (LED_W'(2) << pos_q) - LED_W'(1);
        end else begin
            lights = LED_W'(1) << pos_q;
        end
    end

    assign position   = pos_q;
    assign cycle_done = cycle_done_q;

endmodule

// File: tb/tb_led_scanner.sv
// Directed bench for led_scanner: four instances cover the scan modes, prescaling,
// enable hold and asynchronous reset with hand-computed expected sequences.
module tb_led_scanner;

    logic inclk = 1'b0;
    always #5 inclk = ~inclk;

    int checks   = 0;
    int failures = 0;

    // Instance a: N_LEDS=8, DIV=1
    logic       rst_a, en_a;
    logic [1:0] mode_a;
    logic [7:0] lights_a;
    logic [2:0] pos_a;
    logic       cd_a;

    // Instance b: N_LEDS=5, DIV=3
    logic       rst_b, en_b;
    logic [1:0] mode_b;
    logic [4:0] lights_b;
    logic [2:0] pos_b;
    logic       cd_b;

    // Instance c: N_LEDS=6, DIV=1
    logic       rst_c, en_c;
    logic [1:0] mode_c;
    logic [5:0] lights_c;
    logic [2:0] pos_c;
    logic       cd_c;

    // Instance d: N_LEDS=8, DIV=4
    logic       rst_d, en_d;
    logic [1:0] mode_d;
    logic [7:0] lights_d;
    logic [2:0] pos_d;
    logic       cd_d;

    led_scanner #(.N_LEDS(8), .DIV(1)) u_a (
        .inclk(inclk), .reset(rst_a), .enable(en_a), .mode(mode_a),
        .lights(lights_a), .position(pos_a), .cycle_done(cd_a)
    );
    led_scanner #(.N_LEDS(5), .DIV(3)) u_b (
        .inclk(inclk), .reset(rst_b), .enable(en_b), .mode(mode_b),
        .lights(lights_b), .position(pos_b), .cycle_done(cd_b)
    );
    led_scanner #(.N_LEDS(6), .DIV(1)) u_c (
        .inclk(inclk), .reset(rst_c), .enable(en_c), .mode(mode_c),
        .lights(lights_c), .position(pos_c), .cycle_done(cd_c)
    );
    led_scanner #(.N_LEDS(8), .DIV(4)) u_d (
        .inclk(inclk), .reset(rst_d), .enable(en_d), .mode(mode_d),
        .lights(lights_d), .position(pos_d), .cycle_done(cd_d)
    );

    int         bounce_pos [14] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0};
    int         wdown_pos  [7]  = '{0, 4, 3, 2, 1, 0, 4};
    logic [5:0] fill_lights [6] = '{6'b000001, 6'b000011, 6'b000111,
                                    6'b001111, 6'b011111, 6'b111111};
    logic [7:0] onehot8 [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    logic [4:0] onehot5 [5] = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10};

    task automatic step();
        @(posedge inclk);
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1'b1; en_a = 1'b1; mode_a = 2'd0;
        rst_b = 1'b1; en_b = 1'b1; mode_b = 2'd2;
        rst_c = 1'b1; en_c = 1'b1; mode_c = 2'd3;
        rst_d = 1'b1; en_d = 1'b1; mode_d = 2'd1;
        step();
        step();
        checks++;
        if (pos_a !== 3'd0) begin
            failures++; $display("FAIL reset_pos got=%0d exp=0", pos_a);
        end
        checks++;
        if (lights_a !== 8'h01) begin
            failures++; $display("FAIL reset_lights_bounce got=%b exp=00000001", lights_a);
        end
        checks++;
        if (cd_a !== 1'b0) begin
            failures++; $display("FAIL reset_cycle_done got=%b exp=0", cd_a);
        end
        checks++;
        if (lights_b !== 5'h01) begin
            failures++; $display("FAIL reset_lights_wdown got=%b exp=00001", lights_b);
        end
        checks++;
        if (lights_c !== 6'h01) begin
            failures++; $display("FAIL reset_lights_fill got=%b exp=000001", lights_c);
        end
        checks++;
        if (lights_d !== 8'h01) begin
            failures++; $display("FAIL reset_lights_wup got=%b exp=00000001", lights_d);
        end
    endtask

    task automatic test_bounce();
        int e;
        rst_a = 1'b1; mode_a = 2'd0; en_a = 1'b1;
        step();
        rst_a = 1'b0;
        for (int k = 1; k <= 28; k++) begin
            step();
            e = bounce_pos[(k - 1) % 14];
            checks++;
            if (pos_a !== 3'(e)) begin
                failures++; $display("FAIL bounce_pos k=%0d got=%0d exp=%0d", k, pos_a, e);
            end
            checks++;
            if (lights_a !== onehot8[e]) begin
                failures++; $display("FAIL bounce_lights k=%0d got=%b exp=%b", k, lights_a, onehot8[e]);
            end
            checks++;
            if (cd_a !== ((k % 14) == 0)) begin
                failures++; $display("FAIL bounce_cycle_done k=%0d got=%b", k, cd_a);
            end
        end
    endtask

    task automatic test_wrap_down();
        int e;
        rst_b = 1'b1; mode_b = 2'd2; en_b = 1'b1;
        step();
        rst_b = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            step();
            e = wdown_pos[k / 3];
            checks++;
            if (pos_b !== 3'(e)) begin
                failures++; $display("FAIL wdown_pos k=%0d got=%0d exp=%0d", k, pos_b, e);
            end
            checks++;
            if (lights_b !== onehot5[e]) begin
                failures++; $display("FAIL wdown_lights k=%0d got=%b exp=%b", k, lights_b, onehot5[e]);
            end
            checks++;
            if (cd_b !== (k == 3 || k == 18)) begin
                failures++; $display("FAIL wdown_cycle_done k=%0d got=%b", k, cd_b);
            end
        end
    endtask

    task automatic test_fill();
        rst_c = 1'b1; mode_c = 2'd3; en_c = 1'b1;
        step();
        rst_c = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            checks++;
            if (pos_c !== 3'(k % 6)) begin
                failures++; $display("FAIL fill_pos k=%0d got=%0d exp=%0d", k, pos_c, k % 6);
            end
            checks++;
            if (lights_c !== fill_lights[k % 6]) begin
                failures++; $display("FAIL fill_lights k=%0d got=%b exp=%b", k, lights_c, fill_lights[k % 6]);
            end
            checks++;
            if (cd_c !== ((k % 6) == 0)) begin
                failures++; $display("FAIL fill_cycle_done k=%0d got=%b", k, cd_c);
            end
        end
    endtask

    task automatic test_mode_switch();
        rst_a = 1'b1; mode_a = 2'd0; en_a = 1'b1;
        step();
        rst_a = 1'b0;
        repeat (7) step();
        checks++;
        if (pos_a !== 3'd7) begin
            failures++; $display("FAIL switch_at_end got=%0d exp=7", pos_a);
        end
        mode_a = 2'd1;
        step();
        checks++;
        if (pos_a !== 3'd0) begin
            failures++; $display("FAIL switch_wrap_pos got=%0d exp=0", pos_a);
        end
        checks++;
        if (cd_a !== 1'b1) begin
            failures++; $display("FAIL switch_cycle_done got=%b exp=1", cd_a);
        end
        step();
        checks++;
        if (pos_a !== 3'd1 || cd_a !== 1'b0) begin
            failures++; $display("FAIL switch_next got pos=%0d cd=%b exp pos=1 cd=0", pos_a, cd_a);
        end
        mode_a = 2'd0;
    endtask

    task automatic test_bounce_endpoint();
        rst_c = 1'b1; mode_c = 2'd2; en_c = 1'b1;
        step();
        rst_c = 1'b0;
        step();
        checks++;
        if (pos_c !== 3'd5 || cd_c !== 1'b1) begin
            failures++; $display("FAIL endpoint_wdown got pos=%0d cd=%b exp pos=5 cd=1", pos_c, cd_c);
        end
        mode_c = 2'd0;
        step();
        checks++;
        if (pos_c !== 3'd4) begin
            failures++; $display("FAIL endpoint_bounce_away got=%0d exp=4", pos_c);
        end
        step();
        checks++;
        if (pos_c !== 3'd3 || cd_c !== 1'b0) begin
            failures++; $display("FAIL endpoint_bounce_keep got pos=%0d cd=%b exp pos=3 cd=0", pos_c, cd_c);
        end
    endtask

    task automatic test_enable_hold();
        rst_d = 1'b1; mode_d = 2'd1; en_d = 1'b1;
        step();
        rst_d = 1'b0;
        repeat (14) step();
        checks++;
        if (pos_d !== 3'd3) begin
            failures++; $display("FAIL hold_start got=%0d exp=3", pos_d);
        end
        en_d = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            checks++;
            if (pos_d !== 3'd3 || cd_d !== 1'b0) begin
                failures++; $display("FAIL hold_frozen k=%0d got pos=%0d cd=%b exp pos=3 cd=0", k, pos_d, cd_d);
            end
        end
        en_d = 1'b1;
        step();
        checks++;
        if (pos_d !== 3'd3) begin
            failures++; $display("FAIL hold_resume1 got=%0d exp=3", pos_d);
        end
        step();
        checks++;
        if (pos_d !== 3'd4 || lights_d !== 8'h10) begin
            failures++; $display("FAIL hold_resume2 got pos=%0d lights=%b exp pos=4 lights=00010000", pos_d, lights_d);
        end
    endtask

    task automatic test_async_reset();
        rst_a = 1'b1; mode_a = 2'd0; en_a = 1'b1;
        step();
        rst_a = 1'b0;
        repeat (5) step();
        checks++;
        if (pos_a !== 3'd5) begin
            failures++; $display("FAIL areset_pre got=%0d exp=5", pos_a);
        end
        #3;
        rst_a = 1'b1;
        #1;
        checks++;
        if (lights_a !== 8'h01 || pos_a !== 3'd0) begin
            failures++; $display("FAIL areset_immediate got lights=%b pos=%0d exp lights=00000001 pos=0", lights_a, pos_a);
        end
        checks++;
        if (cd_a !== 1'b0) begin
            failures++; $display("FAIL areset_cycle_done got=%b exp=0", cd_a);
        end
        step();
        checks++;
        if (lights_a !== 8'h01 || cd_a !== 1'b0) begin
            failures++; $display("FAIL areset_held got lights=%b cd=%b", lights_a, cd_a);
        end
        rst_a = 1'b0;
        step();
        checks++;
        if (pos_a !== 3'd1 || cd_a !== 1'b0) begin
            failures++; $display("FAIL areset_release got pos=%0d cd=%b exp pos=1 cd=0", pos_a, cd_a);
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_wrap_down();
        test_fill();
        test_mode_switch();
        test_bounce_endpoint();
        test_enable_hold();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
